preg_free_list: RTL and testbench

- Physical-register free-list manager for the rename stage.
- Hands out up to ALLOC_W distinct free physical registers per cycle to the rename lanes.
- Reclaims old aliases from retiring instructions and tracks the committed (architectural) mapping set.
- On a pipeline flush, rebuilds the free pool from that committed set.
- Replaces ad-hoc free-pool bit twiddling inside the decoder.

---
 rtl/preg_free_list_if.sv | 27 ++
 rtl/preg_free_list.sv | 112 +++++++++++
 tb/tb_preg_free_list.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_if.sv
// Rename-side handshake for the physical-register free list: allocation
// requests and grants, retire releases, flush, and status.
interface preg_free_list_if #(
  parameter int PR_ADDR_W = 5,
  parameter int ALLOC_W   = 4,
  parameter int RET_W     = 4
);
  logic [ALLOC_W-1:0]           alloc_req;
  logic                         alloc_grant;
  logic [ALLOC_W*PR_ADDR_W-1:0] alloc_pregs;
  logic [RET_W-1:0]             ret_valid;
  logic [RET_W*PR_ADDR_W-1:0]   ret_new_preg;
  logic [RET_W*PR_ADDR_W-1:0]   ret_old_preg;
  logic                         flush;
  logic [PR_ADDR_W:0]           free_count;
  logic                         err_double_free;

  modport master (
    output alloc_req, ret_valid, ret_new_preg, ret_old_preg, flush,
    input  alloc_grant, alloc_pregs, free_count, err_double_free
  );

  modport slave (
    input  alloc_req, ret_valid, ret_new_preg, ret_old_preg, flush,
    output alloc_grant, alloc_pregs, free_count, err_double_free
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical-register free list: all-or-nothing multi-lane allocation from
// registered state, retire-driven reclaim, and flush rebuild from the committed set.
module preg_free_list #(
  parameter int NUM_PREGS = 32,
  parameter int PR_ADDR_W = 5,
  parameter int NUM_ARCH  = 10,
  parameter int ALLOC_W   = 4,
  parameter int RET_W     = 4
) (
  input logic clk,
  input logic rst,
  preg_free_list_if.slave bus
);
  localparam int CNT_W = $clog2(ALLOC_W + 1);

  logic [NUM_PREGS-1:0]         free_map, commit_map;
  logic [NUM_PREGS-1:0]         free_nxt, commit_nxt;
  logic [NUM_PREGS-1:0]         avail, taken, rel;
  logic [PR_ADDR_W:0]           free_count;
  logic                         err_q;
  logic [CNT_W-1:0]             n_req;
  logic                         grant;
  logic [ALLOC_W*PR_ADDR_W-1:0] pregs;
  logic                         found;
  logic [PR_ADDR_W-1:0]         sel;
  logic [PR_ADDR_W-1:0]         old_p, new_p;
  logic                         illegal;

  // Each requesting lane takes the lowest free preg not already claimed by a lower lane.
  always_comb begin
    n_req = '0;
    for (int i = 0; i < ALLOC_W; i++) n_req += CNT_W'(bus.alloc_req[i]);
    grant = !bus.flush && !rst && (free_count >= (PR_ADDR_W+1)'(n_req));
    avail = free_map;
    taken = '0;
    pregs = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (bus.alloc_req[i]) begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_PREGS; k++) begin
          if (!found && avail[k]) begin
            found = 1'b1;
            sel   = PR_ADDR_W'(k);
          end
        end
        if (found) begin
          avail[sel] = 1'b0;
          taken[sel] = 1'b1;
          pregs[i*PR_ADDR_W +: PR_ADDR_W] = sel;
        end
      end
    end
    if (!grant) begin
      taken = '0;
      pregs = '0;
    end
  end

  // Releases are judged against registered state; a second release of the same
  // preg in one cycle counts as a double free.
  always_comb begin
    commit_nxt = commit_map;
    rel        = '0;
    illegal    = 1'b0;
    old_p      = '0;
    new_p      = '0;
    for (int j = 0; j < RET_W; j++) begin
      if (bus.ret_valid[j]) begin
        old_p = bus.ret_old_preg[j*PR_ADDR_W +: PR_ADDR_W];
        new_p = bus.ret_new_preg[j*PR_ADDR_W +: PR_ADDR_W];
        if (free_map[old_p] || !commit_map[old_p] || old_p == new_p || rel[old_p]) begin
          illegal = 1'b1;
        end else begin
          rel[old_p]        = 1'b1;
          commit_nxt[old_p] = 1'b0;
          commit_nxt[new_p] = 1'b1;
        end
      end
    end
    free_nxt = bus.flush ? ~commit_nxt : ((free_map & ~taken) | rel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map   <= {{(NUM_PREGS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
      commit_map <= {{(NUM_PREGS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
      free_count <= (PR_ADDR_W+1)'(NUM_PREGS - NUM_ARCH);
      err_q      <= 1'b0;
    end else begin
      free_map   <= free_nxt;
      commit_map <= commit_nxt;
      free_count <= (PR_ADDR_W+1)'($countones(free_nxt));
      if (illegal) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((free_map & commit_map) == '0);
      assert (free_count == (PR_ADDR_W+1)'($countones(free_map)));
      assert ($countones(commit_map) == NUM_ARCH);
    end
  end

  assign bus.alloc_grant     = grant;
  assign bus.alloc_pregs     = pregs;
  assign bus.free_count      = free_count;
  assign bus.err_double_free = err_q;
endmodule

// File: tb/tb_preg_free_list.sv
// Scenario bench for preg_free_list: each task queues stimulus rows with their
// expected outputs, then drives them and checks the DUT cycle by cycle.
module tb_preg_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  preg_free_list_if #(.PR_ADDR_W(5), .ALLOC_W(4), .RET_W(4)) bus ();
  preg_free_list dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rv;
    logic [19:0] rn;
    logic [19:0] ro;
    logic        fl;
  } st_t;

  typedef struct {
    logic        grant;
    logic [19:0] pregs;
    logic [5:0]  count;
    logic        err;
    string       tag;
  } ex_t;

  st_t sq[$];
  ex_t eq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    pk = {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic st_t mk(input logic [3:0] req, input logic [3:0] rv,
                             input int n0, input int o0, input int n1, input int o1,
                             input logic fl);
    st_t s;
    s.req = req; s.rv = rv; s.fl = fl;
    s.rn = pk(n0, n1, 0, 0);
    s.ro = pk(o0, o1, 0, 0);
    return s;
  endfunction

  function automatic ex_t ex(input logic g, input logic [19:0] p, input int c,
                             input logic e, input string t);
    ex_t x;
    x.grant = g; x.pregs = p; x.count = 6'(c); x.err = e; x.tag = t;
    return x;
  endfunction

  task automatic apply(input st_t s);
    bus.alloc_req    = s.req;
    bus.ret_valid    = s.rv;
    bus.ret_new_preg = s.rn;
    bus.ret_old_preg = s.ro;
    bus.flush        = s.fl;
  endtask

  task automatic apply_reset();
    apply(mk(4'b0, 4'b0, 0, 0, 0, 0, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ex_t e;
    rst = 1'b1;
    apply(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0));
    @(negedge clk);
    #1;
    total++;
    if (bus.alloc_grant !== 1'b0) begin
      bad++; $display("FAIL reset_grant got=%b want=0", bus.alloc_grant);
    end
    total++;
    if (bus.free_count !== 6'd22) begin
      bad++; $display("FAIL reset_count got=%0d want=22", bus.free_count);
    end
    @(negedge clk);
    rst = 1'b0;
    sq.push_back(mk(4'b0, 4'b0, 0, 0, 0, 0, 1'b0));
    eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 22, 1'b0, "post_reset_idle"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  // Shared row runner body is repeated per task so each scenario owns its checks.
  task automatic test_alloc_full();
    ex_t e;
    apply_reset();
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(10, 11, 12, 13), 22, 1'b0, "full_a"));
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(14, 15, 16, 17), 18, 1'b0, "full_b"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 14, 1'b0, "full_c"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alloc_sparse();
    ex_t e;
    apply_reset();
    sq.push_back(mk(4'b1010, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 10, 0, 11), 22, 1'b0, "sparse_a"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 20, 1'b0, "sparse_b"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_exhaust();
    ex_t e;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0));
      eq.push_back(ex(1'b1, pk(10+4*c, 11+4*c, 12+4*c, 13+4*c), 22-4*c, 1'b0, "exh_fill"));
    end
    sq.push_back(mk(4'b0011, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(30, 31, 0, 0), 2, 1'b0, "exh_last"));
    sq.push_back(mk(4'b0001, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b0, pk(0, 0, 0, 0), 0, 1'b0, "exh_empty"));
    sq.push_back(mk(4'b0001, 4'b0001, 10, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b0, pk(0, 0, 0, 0), 0, 1'b0, "exh_no_bypass"));
    sq.push_back(mk(4'b0001, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 1, 1'b0, "exh_reclaim"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 0, 1'b0, "exh_after"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_retire_alloc_same();
    ex_t e;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0));
      eq.push_back(ex(1'b1, pk(10+4*c, 11+4*c, 12+4*c, 13+4*c), 22-4*c, 1'b0, "same_fill"));
    end
    sq.push_back(mk(4'b0011, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(26, 27, 0, 0), 6, 1'b0, "same_fill2"));
    sq.push_back(mk(4'b1111, 4'b0001, 10, 3, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(28, 29, 30, 31), 4, 1'b0, "same_both"));
    sq.push_back(mk(4'b0001, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(3, 0, 0, 0), 1, 1'b0, "same_reuse"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 0, 1'b0, "same_after"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    ex_t e;
    apply_reset();
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(10, 11, 12, 13), 22, 1'b0, "fl_a"));
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(14, 15, 16, 17), 18, 1'b0, "fl_b"));
    sq.push_back(mk(4'b1111, 4'b0001, 10, 0, 0, 0, 1'b1)); eq.push_back(ex(1'b0, pk(0, 0, 0, 0), 14, 1'b0, "fl_cycle"));
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 11, 12, 13), 22, 1'b0, "fl_rebuilt"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 18, 1'b0, "fl_after"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_double_free();
    ex_t e;
    apply_reset();
    sq.push_back(mk(4'b0000, 4'b0001, 10, 20, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 22, 1'b0, "df_free_old"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 22, 1'b1, "df_set"));
    sq.push_back(mk(4'b0000, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 22, 1'b1, "df_sticky"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
    // Two ports releasing the same old preg: only port 0 takes effect.
    apply_reset();
    sq.push_back(mk(4'b1111, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(10, 11, 12, 13), 22, 1'b0, "dup_alloc"));
    sq.push_back(mk(4'b0000, 4'b0011, 10, 1, 11, 1, 1'b0)); eq.push_back(ex(1'b1, pk(0, 0, 0, 0), 18, 1'b0, "dup_ret"));
    sq.push_back(mk(4'b0001, 4'b0, 0, 0, 0, 0, 1'b0)); eq.push_back(ex(1'b1, pk(1, 0, 0, 0), 19, 1'b1, "dup_after"));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      #1;
      e = eq.pop_front();
      total++;
      if (bus.alloc_grant !== e.grant || bus.alloc_pregs !== e.pregs) begin
        bad++; $display("FAIL %s grant/pregs got=%b/%h want=%b/%h", e.tag, bus.alloc_grant, bus.alloc_pregs, e.grant, e.pregs);
      end
      total++;
      if (bus.free_count !== e.count || bus.err_double_free !== e.err) begin
        bad++; $display("FAIL %s count/err got=%0d/%b want=%0d/%b", e.tag, bus.free_count, bus.err_double_free, e.count, e.err);
      end
      @(negedge clk);
    end
    apply_reset();
    #1;
    total++;
    if (bus.err_double_free !== 1'b0 || bus.free_count !== 6'd22) begin
      bad++; $display("FAIL df_reset_clear count/err got=%0d/%b want=22/0", bus.free_count, bus.err_double_free);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_full();
    test_alloc_sparse();
    test_exhaust();
    test_retire_alloc_same();
    test_flush();
    test_double_free();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
